// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, reset
// addresses, instruction size and the word-alignment helper.
package fetch_sequencer_pkg;

    localparam int PC_W = 8;

    localparam logic [PC_W-1:0] PC_RESET    = 8'd0;
    localparam logic [PC_W-1:0] NPC_RESET   = 8'd4;
    localparam logic [PC_W-1:0] INSTR_BYTES = 8'd4;

    // Encoding 2'b11 is never produced; it is recovered to SEQ by the FSM.
    typedef enum logic [1:0] {
        SEQ      = 2'b00,
        DS_EXEC  = 2'b01,
        DS_ANNUL = 2'b10
    } ds_state_t;

    // Transfer targets are byte addresses; fetch is always word aligned.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the ID-stage control inputs and the fetch address outputs.
// Handshake: there is no valid/ready pair; LE is the single advance
// qualifier. A rising Clk with LE=1 consumes the ID inputs and updates the
// outputs; with LE=0 every output holds and the ID inputs are ignored.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic            LE;
    logic            ID_B_instr;
    logic            ID_cond_true;
    logic            ID_29_a;
    logic            ID_ba;
    logic            ID_Call_instr;
    logic            ID_jmpl_instr;
    logic [PC_W-1:0] ID_target;
    logic [PC_W-1:0] PC;
    logic [PC_W-1:0] nPC;
    logic            annul_ds;
    logic [1:0]      ds_state;

    // Pipeline side: drives the ID decode, observes the fetch address.
    modport master (
        output LE, ID_B_instr, ID_cond_true, ID_29_a, ID_ba,
               ID_Call_instr, ID_jmpl_instr, ID_target,
        input  PC, nPC, annul_ds, ds_state
    );

    // Sequencer side.
    modport slave (
        input  LE, ID_B_instr, ID_cond_true, ID_29_a, ID_ba,
               ID_Call_instr, ID_jmpl_instr, ID_target,
        output PC, nPC, annul_ds, ds_state
    );

endinterface

// File: rtl/fetch_sequencer_pc_adder4.sv
// Adds one instruction (4 bytes) to an 8-bit address, wrapping modulo 256.
module pc_adder4
    import fetch_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] a,
    output logic [PC_W-1:0] y
);

    // Carry out of the top bit is deliberately dropped.
    always_comb begin
        y = a + INSTR_BYTES;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch address sequencer with one delay slot after every control transfer.
// PC/nPC advance sequentially unless the instruction in ID is a taken call,
// jmpl or branch; the slot after an annulling branch is flagged by annul_ds.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic              Clk,
    input  logic              R,
    fetch_sequencer_if.slave  bus
);

    ds_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] npc_q, npc_d;
    logic            annul_q, annul_d;

    logic [PC_W-1:0] tgt_aligned;
    logic [PC_W-1:0] npc_plus4;
    logic [PC_W-1:0] tgt_plus4;
    logic            dcti_uncond;
    logic            taken;
    logic            annul_req;

    pc_adder4 u_npc_inc (
        .a (npc_q),
        .y (npc_plus4)
    );

    pc_adder4 u_tgt_inc (
        .a (tgt_aligned),
        .y (tgt_plus4)
    );

    // Decode the ID instruction into taken / annul decisions.
    always_comb begin
        tgt_aligned = align_word(bus.ID_target);
        // Call and jmpl outrank a branch, so they also suppress its annul bit.
        dcti_uncond = bus.ID_Call_instr | bus.ID_jmpl_instr;
        taken       = dcti_uncond | (bus.ID_B_instr & bus.ID_cond_true);
        annul_req   = ~dcti_uncond & bus.ID_B_instr & bus.ID_29_a &
                      (~bus.ID_cond_true | bus.ID_ba);
    end

    // Next-state and next-address selection; LE=0 keeps every default.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        annul_d = annul_q;
        if (bus.LE) begin
            case (state_q)
                SEQ: begin
                    if (taken) begin
                        pc_d  = tgt_aligned;
                        npc_d = tgt_plus4;
                    end else begin
                        pc_d  = npc_q;
                        npc_d = npc_plus4;
                    end
                    if (annul_req) begin
                        state_d = DS_ANNUL;
                        annul_d = 1'b1;
                    end else if (taken) begin
                        state_d = DS_EXEC;
                        annul_d = 1'b0;
                    end else begin
                        state_d = SEQ;
                        annul_d = 1'b0;
                    end
                end
                // The delay slot leaves ID on this edge; transfer inputs in
                // the slot itself are not honoured.
                DS_EXEC, DS_ANNUL: begin
                    pc_d    = npc_q;
                    npc_d   = npc_plus4;
                    state_d = SEQ;
                    annul_d = 1'b0;
                end
                // Unused encoding: behave like the end of a delay slot.
                default: begin
                    pc_d    = npc_q;
                    npc_d   = npc_plus4;
                    state_d = SEQ;
                    annul_d = 1'b0;
                end
            endcase
        end
    end

    // State and address registers; reset abandons any pending transfer.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state_q <= SEQ;
            pc_q    <= PC_RESET;
            npc_q   <= NPC_RESET;
            annul_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            annul_q <= annul_d;
        end
    end

    // Registered outputs straight from the flops.
    always_comb begin
        bus.PC       = pc_q;
        bus.nPC      = npc_q;
        bus.annul_ds = annul_q;
        bus.ds_state = state_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  typedef struct {
    logic       le;
    logic       b;
    logic       cond;
    logic       a;
    logic       ba;
    logic       call;
    logic       jmpl;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic [7:0] npc;
    logic       an;
    logic [1:0] st;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vq[$];
  logic [18:0] exp_q[$];

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .Clk (clk),
    .R   (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pc, input logic [7:0] npc,
                         input logic an, input logic [1:0] st);
    chk({tag, " PC"}, bus.PC, pc);
    chk({tag, " nPC"}, bus.nPC, npc);
    chk({tag, " annul_ds"}, {7'd0, bus.annul_ds}, {7'd0, an});
    chk({tag, " ds_state"}, {6'd0, bus.ds_state}, {6'd0, st});
  endtask

  // driver
  task automatic drive(input logic le, input logic b, input logic cond, input logic a,
                       input logic ba, input logic call, input logic jmpl, input logic [7:0] tgt);
    bus.LE            = le;
    bus.ID_B_instr    = b;
    bus.ID_cond_true  = cond;
    bus.ID_29_a       = a;
    bus.ID_ba         = ba;
    bus.ID_Call_instr = call;
    bus.ID_jmpl_instr = jmpl;
    bus.ID_target     = tgt;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic add(input logic le, input logic b, input logic cond, input logic a,
                     input logic ba, input logic call, input logic jmpl, input logic [7:0] tgt,
                     input logic [7:0] pc, input logic [7:0] npc, input logic an, input logic [1:0] st);
    vec_t v;
    v.le = le; v.b = b; v.cond = cond; v.a = a; v.ba = ba; v.call = call; v.jmpl = jmpl;
    v.tgt = tgt; v.pc = pc; v.npc = npc; v.an = an; v.st = st;
    vq.push_back(v);
  endtask

  initial begin
    logic [18:0] e;
    n_tests = 0;
    n_fail  = 0;

    // vectors: le b cond a ba call jmpl tgt | pc npc annul state
    add(1,0,0,0,0,0,0,8'h00,  8'd4,   8'd8,   0, 2'b00); // reset release -> 4
    add(1,0,0,0,0,0,0,8'h00,  8'd8,   8'd12,  0, 2'b00);
    add(1,1,1,0,0,0,0,8'd40,  8'd40,  8'd44,  0, 2'b01); // taken branch a=0
    add(1,0,0,0,0,0,0,8'h00,  8'd44,  8'd48,  0, 2'b00); // slot done
    add(1,1,0,1,0,0,0,8'd99,  8'd48,  8'd52,  1, 2'b10); // not taken, a=1
    add(1,0,0,0,0,1,0,8'h10,  8'd52,  8'd56,  0, 2'b00); // call in slot ignored
    add(1,1,1,1,1,0,0,8'h80,  8'h80,  8'h84,  1, 2'b10); // ba,a=1
    add(1,0,0,0,0,0,0,8'h00,  8'h84,  8'h88,  0, 2'b00);
    add(1,1,1,1,1,1,0,8'h80,  8'h80,  8'h84,  0, 2'b01); // call wins over ba,a
    add(1,0,0,0,0,0,0,8'h00,  8'h84,  8'h88,  0, 2'b00);
    add(0,1,1,0,0,0,0,8'h40,  8'h84,  8'h88,  0, 2'b00); // stall x3
    add(0,1,1,0,0,0,0,8'h40,  8'h84,  8'h88,  0, 2'b00);
    add(0,1,1,0,0,0,0,8'h40,  8'h84,  8'h88,  0, 2'b00);
    add(1,0,0,0,0,0,1,8'hF7,  8'hF4,  8'hF8,  0, 2'b01); // jmpl, target aligned
    add(1,0,0,0,0,0,0,8'h00,  8'hF8,  8'hFC,  0, 2'b00);
    add(1,0,0,0,0,0,0,8'h00,  8'hFC,  8'h00,  0, 2'b00); // PC=252, nPC wraps
    add(1,0,0,0,0,0,0,8'h00,  8'h00,  8'h04,  0, 2'b00);
    add(1,1,1,1,0,0,0,8'h22,  8'h20,  8'h24,  0, 2'b01); // taken, a=1, not ba
    add(0,0,0,0,0,1,0,8'h60,  8'h20,  8'h24,  0, 2'b01); // stall in slot
    add(1,0,0,0,0,0,0,8'h00,  8'h24,  8'h28,  0, 2'b00);
    add(1,1,0,0,0,0,0,8'h50,  8'h28,  8'h2C,  0, 2'b00); // not taken, a=0
    add(1,0,1,1,1,0,0,8'h50,  8'h2C,  8'h30,  0, 2'b00); // cond without branch
    add(1,0,0,0,0,1,0,8'hFE,  8'hFC,  8'h00,  0, 2'b01); // call to 0xFE -> FC, wrap

    // reset state, before any clock edge
    rst = 1'b1;
    idle();
    #1;
    chk_all("reset", 8'd0, 8'd4, 1'b0, 2'b00);
    #2 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].le, vq[i].b, vq[i].cond, vq[i].a, vq[i].ba, vq[i].call, vq[i].jmpl, vq[i].tgt);
      exp_q.push_back({vq[i].pc, vq[i].npc, vq[i].an, vq[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      chk_all($sformatf("vec%0d", i), e[18:11], e[10:3], e[2], e[1:0]);
    end

    // reset held across an edge with a transfer pending has no effect
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    #1;
    chk_all("rst_async", 8'd0, 8'd4, 1'b0, 2'b00);
    @(negedge clk);
    chk_all("rst_held", 8'd0, 8'd4, 1'b0, 2'b00);
    rst = 1'b0;
    idle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk_all($sformatf("seq%0d", i), 8'(4 * i), 8'(4 * i + 4), 1'b0, 2'b00);
    end

    // annulled slot from PC=16, stall keeps annul_ds, then reset mid-slot
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h70);
    @(negedge clk);
    chk_all("annul", 8'd20, 8'd24, 1'b1, 2'b10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk_all("annul_stall", 8'd20, 8'd24, 1'b1, 2'b10);
    idle();
    rst = 1'b1;
    #1;
    chk_all("rst_in_annul", 8'd0, 8'd4, 1'b0, 2'b00);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all("after_rst", 8'd4, 8'd8, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
